// File: rtl/layer_argmax_stream.sv
// layer_argmax_stream: streaming argmax over M-word signed vectors.
// Ports:
//   clk, reset (async, active-high)
//   s_valid/s_ready/data_in  : input word stream
//   m_valid/m_ready          : result handshake
//   idx_out/max_out          : index and value of the maximum
module layer_argmax_stream #(
    parameter int M    = 16,
    parameter int T    = 16,
    parameter int logM = $clog2(M)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [T-1:0]    data_in,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [logM-1:0] idx_out,
    output logic [T-1:0]    max_out
);

    localparam logic [logM-1:0] LAST = logM'(M - 1);

    logic [logM-1:0]    count;
    logic [logM-1:0]    cur_idx;
    logic [logM-1:0]    nxt_idx;
    logic signed [T-1:0] cur_max;
    logic signed [T-1:0] nxt_max;
    logic               accept;
    logic               last;
    logic               first;
    logic               bigger;

    assign last  = (count == LAST);
    assign first = (count == '0);

    // Only the closing word must wait: it would overwrite a held result.
    assign s_ready = !reset && !(m_valid && !m_ready && last);
    assign accept  = s_valid && s_ready;

    // Strict compare so ties keep the lower index.
    assign bigger = !first && ($signed(data_in) > cur_max);

    // Running max including the current word; word 0 seeds it.
    always_comb begin
        nxt_max = cur_max;
        nxt_idx = cur_idx;
        unique case (1'b1)
            first: begin
                nxt_max = $signed(data_in);
                nxt_idx = '0;
            end
            bigger: begin
                nxt_max = $signed(data_in);
                nxt_idx = count;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            cur_max <= '0;
            cur_idx <= '0;
            idx_out <= '0;
            max_out <= '0;
            m_valid <= 1'b0;
        end else begin
            if (accept) begin
                cur_max <= nxt_max;
                cur_idx <= nxt_idx;
                count   <= last ? '0 : count + 1'b1;
            end
            // A completion may coincide with a transfer: reload, no bubble.
            if (accept && last) begin
                max_out <= nxt_max;
                idx_out <= nxt_idx;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
